// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: default widths and the PC generator
// state encoding.
package riscv_pkg;

  // Default program-counter width in bits.
  localparam int XLEN_DEF   = 32;
  // Default instruction alignment / sequential increment in bytes.
  localparam int IALIGN_DEF = 4;
  // Default width of the accepted-fetch counter.
  localparam int CNT_W_DEF  = 16;

  // PC generator states: BOOT is the single post-reset bubble, RUN issues
  // addresses, HALT parks the block after a misaligned redirect.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

endpackage : riscv_pkg

// File: rtl/pc_gen.sv
// Program-counter generator. Issues sequential fetch addresses with a
// valid/ready handshake and applies traps and redirects with a one-cycle
// latency. Traps beat redirects, and redirects beat sequential advance.
// A redirect to a misaligned target is refused: the block flags it, records
// the target and parks in HALT until a trap or reset.
module pc_gen
  import riscv_pkg::*;
#(
  parameter int               XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_VECTOR = {XLEN{1'b0}},
  parameter int               IALIGN       = IALIGN_DEF,
  parameter int               CNT_W        = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_i,
  input  logic              redirect_valid_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  input  logic              trap_valid_i,
  input  logic [XLEN-1:0]   trap_vec_i,
  input  logic              pc_ready_i,
  output logic [XLEN-1:0]   pc_o,
  output logic              pc_valid_o,
  output logic              misalign_o,
  output logic [XLEN-1:0]   misalign_addr_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  // Only halfword (compressed) and word alignment make sense here.
  if ((IALIGN != 2) && (IALIGN != 4)) begin : g_bad_ialign
    $error("pc_gen: IALIGN must be 2 or 4");
  end

  // Low address bits that must be zero for an aligned instruction address.
  localparam logic [XLEN-1:0]  ALIGN_MASK = XLEN'(IALIGN - 1);
  // Sequential step between consecutive fetch addresses.
  localparam logic [XLEN-1:0]  PC_INC     = XLEN'(IALIGN);
  // Counter saturation value.
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  // State and output registers.
  pc_state_e          r_state;
  logic [XLEN-1:0]    r_pc;
  logic               r_misalign;
  logic [XLEN-1:0]    r_misalign_addr;
  logic [CNT_W-1:0]   r_fetch_cnt;

  // Next-state values and combinational helpers.
  pc_state_e          w_state_nxt;
  logic [XLEN-1:0]    w_pc_nxt;
  logic               w_misalign_nxt;
  logic [XLEN-1:0]    w_misalign_addr_nxt;
  logic [CNT_W-1:0]   w_fetch_cnt_nxt;
  logic               w_pc_valid;
  logic               w_handshake;
  logic               w_redirect_aligned;
  logic [XLEN-1:0]    w_trap_pc;

  // Alignment check and trap target with its low alignment bits cleared.
  always_comb begin
    w_redirect_aligned = ((redirect_pc_i & ALIGN_MASK) == {XLEN{1'b0}});
    w_trap_pc          = trap_vec_i & ~ALIGN_MASK;
  end

  // Valid is offered only while running and not stalled by halt_i; a
  // handshake is a valid address that fetch accepts this cycle.
  always_comb begin
    if ((r_state == RUN) && !halt_i) begin
      w_pc_valid = 1'b1;
    end else begin
      w_pc_valid = 1'b0;
    end
    w_handshake = w_pc_valid && pc_ready_i;
  end

  // Next-state, next-PC and misalign-capture decode in priority order.
  always_comb begin
    w_state_nxt         = r_state;
    w_pc_nxt            = r_pc;
    w_misalign_nxt      = 1'b0;
    w_misalign_addr_nxt = r_misalign_addr;
    case (r_state)
      BOOT: begin
        // Single bubble cycle; the reset vector is issued on entry to RUN.
        w_state_nxt = RUN;
        w_pc_nxt    = RESET_VECTOR;
      end
      RUN: begin
        if (trap_valid_i) begin
          w_pc_nxt = w_trap_pc;
        end else if (redirect_valid_i) begin
          if (w_redirect_aligned) begin
            w_pc_nxt = redirect_pc_i;
          end else begin
            // Refuse the target, keep the old PC and park.
            w_state_nxt         = HALT;
            w_misalign_nxt      = 1'b1;
            w_misalign_addr_nxt = redirect_pc_i;
          end
        end else if (w_handshake) begin
          // Wraps naturally modulo 2^XLEN.
          w_pc_nxt = r_pc + PC_INC;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      HALT: begin
        // Redirects are ignored here; only a trap restarts fetch.
        if (trap_valid_i) begin
          w_state_nxt = RUN;
          w_pc_nxt    = w_trap_pc;
        end else begin
          w_state_nxt = HALT;
        end
      end
      default: begin
        // Unreachable encoding: recover through the boot bubble.
        w_state_nxt = BOOT;
        w_pc_nxt    = RESET_VECTOR;
      end
    endcase
  end

  // Saturating count of accepted fetch handshakes.
  always_comb begin
    if (w_handshake && (r_fetch_cnt != CNT_MAX)) begin
      w_fetch_cnt_nxt = r_fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_fetch_cnt_nxt = r_fetch_cnt;
    end
  end

  // State register; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC, misalign report and fetch counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc            <= RESET_VECTOR;
      r_misalign      <= 1'b0;
      r_misalign_addr <= {XLEN{1'b0}};
      r_fetch_cnt     <= {CNT_W{1'b0}};
    end else begin
      r_pc            <= w_pc_nxt;
      r_misalign      <= w_misalign_nxt;
      r_misalign_addr <= w_misalign_addr_nxt;
      r_fetch_cnt     <= w_fetch_cnt_nxt;
    end
  end

  assign pc_o            = r_pc;
  assign pc_valid_o      = w_pc_valid;
  assign misalign_o      = r_misalign;
  assign misalign_addr_o = r_misalign_addr;
  assign fetch_cnt_o     = r_fetch_cnt;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: one instance with default
// parameters and a second with a near-top reset vector and a 2-bit counter
// to exercise address wrap and counter saturation.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        halt_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        trap_valid_i;
  logic [31:0] trap_vec_i;
  logic        pc_ready_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
  logic [15:0] fetch_cnt_o;

  logic        rst2;
  logic        ready2;
  logic [31:0] pc2;
  logic        valid2;
  logic        mis2;
  logic [31:0] mis_addr2;
  logic [1:0]  cnt2;

  int n_checks;
  int n_errors;

  pc_gen u_dut (
    .clk              (clk),
    .rst              (rst),
    .halt_i           (halt_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .trap_valid_i     (trap_valid_i),
    .trap_vec_i       (trap_vec_i),
    .pc_ready_i       (pc_ready_i),
    .pc_o             (pc_o),
    .pc_valid_o       (pc_valid_o),
    .misalign_o       (misalign_o),
    .misalign_addr_o  (misalign_addr_o),
    .fetch_cnt_o      (fetch_cnt_o)
  );

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'hFFFF_FFF4),
    .IALIGN       (4),
    .CNT_W        (2)
  ) u_dut_wrap (
    .clk              (clk),
    .rst              (rst2),
    .halt_i           (1'b0),
    .redirect_valid_i (1'b0),
    .redirect_pc_i    (32'h0000_0000),
    .trap_valid_i     (1'b0),
    .trap_vec_i       (32'h0000_0000),
    .pc_ready_i       (ready2),
    .pc_o             (pc2),
    .pc_valid_o       (valid2),
    .misalign_o       (mis2),
    .misalign_addr_o  (mis_addr2),
    .fetch_cnt_o      (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; halt_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
    trap_valid_i = 1'b0; trap_vec_i = 32'h0; pc_ready_i = 1'b0;
    rst2 = 1'b1; ready2 = 1'b0;

    tick(); tick();
    check("rst_pc",    64'(pc_o), 64'h0);
    check("rst_valid", 64'(pc_valid_o), 64'h0);
    check("rst_mis",   64'(misalign_o), 64'h0);
    check("rst_maddr", 64'(misalign_addr_o), 64'h0);
    check("rst_cnt",   64'(fetch_cnt_o), 64'h0);

    // Release reset: one BOOT cycle with valid low, then sequential fetch.
    rst = 1'b0; pc_ready_i = 1'b1;
    check("boot_valid", 64'(pc_valid_o), 64'h0);
    tick();
    check("run_valid", 64'(pc_valid_o), 64'h1);
    check("seq_pc0", 64'(pc_o), 64'h0);
    tick(); check("seq_pc4", 64'(pc_o), 64'h4);
    tick(); check("seq_pc8", 64'(pc_o), 64'h8);
    tick(); check("seq_pcC", 64'(pc_o), 64'hC);
    tick(); check("seq_pc10", 64'(pc_o), 64'h10);
    check("seq_cnt4", 64'(fetch_cnt_o), 64'h4);

    // Back-pressure holds the address and the counter.
    pc_ready_i = 1'b0;
    tick(); tick(); tick();
    check("stall_pc", 64'(pc_o), 64'h10);
    check("stall_cnt", 64'(fetch_cnt_o), 64'h4);
    check("stall_valid", 64'(pc_valid_o), 64'h1);

    // halt_i drops valid and freezes the PC even with ready high.
    halt_i = 1'b1; pc_ready_i = 1'b1;
    #1 check("halt_valid", 64'(pc_valid_o), 64'h0);
    tick();
    check("halt_pc", 64'(pc_o), 64'h10);
    check("halt_cnt", 64'(fetch_cnt_o), 64'h4);
    halt_i = 1'b0; pc_ready_i = 1'b0;

    // Trap and redirect in the same cycle: trap wins.
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
    trap_valid_i = 1'b1; trap_vec_i = 32'h80;
    tick();
    redirect_valid_i = 1'b0; trap_valid_i = 1'b0;
    check("prio_trap_pc", 64'(pc_o), 64'h80);

    // Aligned redirect alone.
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h300;
    tick();
    redirect_valid_i = 1'b0;
    check("redir_pc", 64'(pc_o), 64'h300);

    // Trap vector low bits are cleared.
    trap_valid_i = 1'b1; trap_vec_i = 32'h123;
    tick();
    trap_valid_i = 1'b0;
    check("trap_mask_pc", 64'(pc_o), 64'h120);

    // Redirect honoured while halt_i is high in RUN.
    halt_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h400;
    tick();
    halt_i = 1'b0; redirect_valid_i = 1'b0;
    check("halt_redir_pc", 64'(pc_o), 64'h400);

    // Misaligned redirect: pulse, capture, park in HALT.
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h102;
    tick();
    redirect_valid_i = 1'b0;
    check("mis_pulse", 64'(misalign_o), 64'h1);
    check("mis_addr", 64'(misalign_addr_o), 64'h102);
    check("mis_valid", 64'(pc_valid_o), 64'h0);
    check("mis_pc_kept", 64'(pc_o), 64'h400);
    tick();
    check("mis_pulse_end", 64'(misalign_o), 64'h0);
    check("mis_addr_hold", 64'(misalign_addr_o), 64'h102);

    // Redirects are ignored in HALT.
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h500; pc_ready_i = 1'b1;
    tick();
    redirect_valid_i = 1'b0;
    check("haltst_redir_pc", 64'(pc_o), 64'h400);
    check("haltst_valid", 64'(pc_valid_o), 64'h0);
    check("haltst_cnt", 64'(fetch_cnt_o), 64'h4);
    pc_ready_i = 1'b0;

    // Trap leaves HALT.
    trap_valid_i = 1'b1; trap_vec_i = 32'h40;
    tick();
    trap_valid_i = 1'b0;
    check("trap_exit_pc", 64'(pc_o), 64'h40);
    check("trap_exit_valid", 64'(pc_valid_o), 64'h1);

    // Re-enter HALT, then reset overrides a pending trap and redirect.
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h102;
    tick();
    redirect_valid_i = 1'b0;
    tick();
    check("rehalt_addr", 64'(misalign_addr_o), 64'h102);
    rst = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h104;
    trap_valid_i = 1'b1; trap_vec_i = 32'h60; pc_ready_i = 1'b1;
    tick();
    check("hrst_pc", 64'(pc_o), 64'h0);
    check("hrst_valid", 64'(pc_valid_o), 64'h0);
    check("hrst_mis", 64'(misalign_o), 64'h0);
    check("hrst_maddr", 64'(misalign_addr_o), 64'h0);
    check("hrst_cnt", 64'(fetch_cnt_o), 64'h0);
    rst = 1'b0; redirect_valid_i = 1'b0; trap_valid_i = 1'b0; pc_ready_i = 1'b0;
    tick();
    check("hrst_boot_pc", 64'(pc_o), 64'h0);

    // Second instance: wrap through zero and 2-bit counter saturation.
    rst2 = 1'b0;
    tick();
    check("w_pc_rv", 64'(pc2), 64'hFFFF_FFF4);
    check("w_valid", 64'(valid2), 64'h1);
    ready2 = 1'b1;
    tick(); check("w_pc_f8", 64'(pc2), 64'hFFFF_FFF8);
    tick(); check("w_pc_fc", 64'(pc2), 64'hFFFF_FFFC);
    tick(); check("w_pc_wrap", 64'(pc2), 64'h0);
    check("w_cnt3", 64'(cnt2), 64'h3);
    tick(); tick();
    check("w_pc_8", 64'(pc2), 64'h8);
    check("w_cnt_sat", 64'(cnt2), 64'h3);
    check("w_mis", 64'(mis2), 64'h0);
    check("w_maddr", 64'(mis_addr2), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pc_gen
